// File: rtl/mem_wb_flag_stage.sv
// MEM/WB pipeline register plus the architectural {C,Z} flag register.
// Commits the condition-resolved flags and the final register write from MEM,
// presents the register-file write port to writeback, pulses a PC redirect on
// committed R7 writes, and counts retired instructions.
module mem_wb_flag_stage #(
    parameter int          DATA_W   = 16,
    parameter int          CNT_W    = 32,
    parameter logic [1:0]  FLAG_RST = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        cz_in,
    input  logic              wr_en_in,
    input  logic [2:0]        rd_in,
    input  logic [DATA_W-1:0] wb_data_in,
    input  logic [15:0]       pc_in,
    output logic [1:0]        flag_reg,
    output logic              wb_valid,
    output logic              rf_we,
    output logic [2:0]        rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [15:0]       wb_pc,
    output logic              r7_redirect,
    output logic [15:0]       redirect_pc,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic [1:0]        r_flag;
    logic              r_wb_valid;
    logic              r_rf_we;
    logic [2:0]        r_rf_addr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic [15:0]       r_wb_pc;
    logic              r_r7_redirect;
    logic [15:0]       r_redirect_pc;
    logic [CNT_W-1:0]  r_retire_cnt;
    logic              r_pend_flush;

    logic              w_take;
    logic              w_r7_wr;

    // A flush seen during a stall is remembered so the held instruction is
    // squashed on the edge where the stall releases.
    assign w_take  = mem_valid & ~flush & ~r_pend_flush;
    assign w_r7_wr = w_take & wr_en_in & (rd_in == 3'd7);

    // Stage register: capture on take, bubble otherwise, hold under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag        <= FLAG_RST;
            r_wb_valid    <= 1'b0;
            r_rf_we       <= 1'b0;
            r_rf_addr     <= 3'd0;
            r_rf_wdata    <= '0;
            r_wb_pc       <= 16'd0;
            r_r7_redirect <= 1'b0;
            r_redirect_pc <= 16'd0;
            r_retire_cnt  <= '0;
            r_pend_flush  <= 1'b0;
        end else if (stall) begin
            // Strobes drop after the first stalled edge so a write lands once;
            // everything else, flags included, is frozen.
            r_rf_we       <= 1'b0;
            r_r7_redirect <= 1'b0;
            if (flush)
                r_pend_flush <= 1'b1;
        end else begin
            r_pend_flush  <= 1'b0;
            r_wb_valid    <= w_take;
            r_rf_we       <= w_take & wr_en_in;
            r_r7_redirect <= w_r7_wr;
            if (w_take) begin
                r_rf_addr    <= rd_in;
                r_rf_wdata   <= wb_data_in;
                r_wb_pc      <= pc_in;
                // A not-taken conditional op still delivers the old flags here.
                r_flag       <= cz_in;
                r_retire_cnt <= r_retire_cnt + 1'b1;
            end
            if (w_r7_wr)
                r_redirect_pc <= wb_data_in[15:0];
        end
    end

    assign flag_reg    = r_flag;
    assign wb_valid    = r_wb_valid;
    assign rf_we       = r_rf_we;
    assign rf_addr     = r_rf_addr;
    assign rf_wdata    = r_rf_wdata;
    assign wb_pc       = r_wb_pc;
    assign r7_redirect = r_r7_redirect;
    assign redirect_pc = r_redirect_pc;
    assign retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_flag_stage.sv
// Directed bench for mem_wb_flag_stage. The retire counter is built 4 bits
// wide here so the wrap case is reachable with a handful of commits.
module tb_mem_wb_flag_stage;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_valid, stall, flush, wr_en_in;
    logic [1:0]        cz_in;
    logic [2:0]        rd_in;
    logic [DATA_W-1:0] wb_data_in;
    logic [15:0]       pc_in;
    logic [1:0]        flag_reg;
    logic              wb_valid, rf_we, r7_redirect;
    logic [2:0]        rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic [15:0]       wb_pc, redirect_pc;
    logic [CNT_W-1:0]  retire_cnt;

    int n_vec = 0;
    int n_err = 0;

    mem_wb_flag_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W), .FLAG_RST(2'b00)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .stall(stall), .flush(flush),
        .cz_in(cz_in), .wr_en_in(wr_en_in), .rd_in(rd_in), .wb_data_in(wb_data_in),
        .pc_in(pc_in), .flag_reg(flag_reg), .wb_valid(wb_valid), .rf_we(rf_we),
        .rf_addr(rf_addr), .rf_wdata(rf_wdata), .wb_pc(wb_pc),
        .r7_redirect(r7_redirect), .redirect_pc(redirect_pc), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one MEM instruction (valid, no stall/flush).
    task automatic drive(input logic [1:0] cz, input logic we, input logic [2:0] rd,
                         input logic [15:0] d, input logic [15:0] pc);
        mem_valid  = 1'b1;
        cz_in      = cz;
        wr_en_in   = we;
        rd_in      = rd;
        wb_data_in = d;
        pc_in      = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        cz_in = 2'b00; wr_en_in = 1'b0; rd_in = 3'd0; wb_data_in = '0; pc_in = '0;
        step();
        chk("rst_flag", 32'(flag_reg), 32'h0);
        chk("rst_wbv", 32'(wb_valid), 32'h0);
        chk("rst_we", 32'(rf_we), 32'h0);
        chk("rst_cnt", 32'(retire_cnt), 32'h0);
        chk("rst_wdata", 32'(rf_wdata), 32'h0);
        chk("rst_r7", 32'(r7_redirect), 32'h0);
        rst = 1'b0;

        // ADD to R3
        drive(2'b10, 1'b1, 3'd3, 16'h1234, 16'h0100);
        step();
        chk("add_we", 32'(rf_we), 32'h1);
        chk("add_addr", 32'(rf_addr), 32'h3);
        chk("add_wdata", 32'(rf_wdata), 32'h1234);
        chk("add_flag", 32'(flag_reg), 32'h2);
        chk("add_cnt", 32'(retire_cnt), 32'h1);
        chk("add_pc", 32'(wb_pc), 32'h0100);
        chk("add_r7", 32'(r7_redirect), 32'h0);

        // Set flags to 01, then a not-taken ADC
        drive(2'b01, 1'b1, 3'd2, 16'h0005, 16'h0102);
        step();
        chk("set_flag", 32'(flag_reg), 32'h1);
        drive(2'b01, 1'b0, 3'd4, 16'hDEAD, 16'h0104);
        step();
        chk("adc_we", 32'(rf_we), 32'h0);
        chk("adc_wbv", 32'(wb_valid), 32'h1);
        chk("adc_flag", 32'(flag_reg), 32'h1);
        chk("adc_cnt", 32'(retire_cnt), 32'h3);

        // Commit 00AA to R3, then stall 3 cycles
        drive(2'b00, 1'b1, 3'd3, 16'h00AA, 16'h0106);
        step();
        chk("stl0_we", 32'(rf_we), 32'h1);
        chk("stl0_cnt", 32'(retire_cnt), 32'h4);
        drive(2'b11, 1'b1, 3'd1, 16'h7777, 16'h0108);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stl_we", 32'(rf_we), 32'h0);
            chk("stl_wdata", 32'(rf_wdata), 32'h00AA);
            chk("stl_wbv", 32'(wb_valid), 32'h1);
            chk("stl_cnt", 32'(retire_cnt), 32'h4);
            chk("stl_flag", 32'(flag_reg), 32'h0);
        end

        // Flush while stalled, then release
        flush = 1'b1;
        step();
        chk("pfl_wbv", 32'(wb_valid), 32'h1);
        flush = 1'b0; stall = 1'b0;
        step();
        chk("pfl_sq_wbv", 32'(wb_valid), 32'h0);
        chk("pfl_sq_we", 32'(rf_we), 32'h0);
        chk("pfl_sq_flag", 32'(flag_reg), 32'h0);
        chk("pfl_sq_cnt", 32'(retire_cnt), 32'h4);
        drive(2'b10, 1'b1, 3'd1, 16'h0BBB, 16'h010A);
        step();
        chk("pfl_nxt_we", 32'(rf_we), 32'h1);
        chk("pfl_nxt_data", 32'(rf_wdata), 32'h0BBB);
        chk("pfl_nxt_flag", 32'(flag_reg), 32'h2);
        chk("pfl_nxt_cnt", 32'(retire_cnt), 32'h5);

        // Immediate flush (no stall)
        drive(2'b01, 1'b1, 3'd2, 16'h0CCC, 16'h010C);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("ifl_wbv", 32'(wb_valid), 32'h0);
        chk("ifl_flag", 32'(flag_reg), 32'h2);
        chk("ifl_cnt", 32'(retire_cnt), 32'h5);
        // the next one must not be squashed by a stale pending flush
        drive(2'b01, 1'b1, 3'd2, 16'h0CCC, 16'h010C);
        step();
        chk("ifl_nxt_we", 32'(rf_we), 32'h1);
        chk("ifl_nxt_cnt", 32'(retire_cnt), 32'h6);

        // Write to R7 -> one-cycle redirect
        drive(2'b00, 1'b1, 3'd7, 16'h0040, 16'h010E);
        step();
        chk("r7_pulse", 32'(r7_redirect), 32'h1);
        chk("r7_pc", 32'(redirect_pc), 32'h0040);
        chk("r7_cnt", 32'(retire_cnt), 32'h7);
        mem_valid = 1'b0;
        step();
        chk("r7_off", 32'(r7_redirect), 32'h0);
        chk("bub_wbv", 32'(wb_valid), 32'h0);
        drive(2'b00, 1'b0, 3'd7, 16'h0080, 16'h0110);
        step();
        chk("r7_nowe", 32'(r7_redirect), 32'h0);
        chk("r7_nowe_cnt", 32'(retire_cnt), 32'h8);

        // Counter wrap: 8 -> 15 -> 0 -> 1
        for (int i = 0; i < 7; i++) begin
            drive(2'b00, 1'b1, 3'd1, 16'(i), 16'h0200);
            step();
        end
        chk("wrap_max", 32'(retire_cnt), 32'hF);
        drive(2'b00, 1'b1, 3'd1, 16'h0001, 16'h0202);
        step();
        chk("wrap_zero", 32'(retire_cnt), 32'h0);
        drive(2'b00, 1'b1, 3'd1, 16'h0002, 16'h0204);
        step();
        chk("wrap_one", 32'(retire_cnt), 32'h1);

        // Async reset in the middle of a stall
        drive(2'b11, 1'b1, 3'd5, 16'h5555, 16'h0300);
        step();
        chk("ar_pre_flag", 32'(flag_reg), 32'h3);
        stall = 1'b1; flush = 1'b1;
        step();
        #2 rst = 1'b1;
        #1;
        chk("ar_flag", 32'(flag_reg), 32'h0);
        chk("ar_wbv", 32'(wb_valid), 32'h0);
        chk("ar_cnt", 32'(retire_cnt), 32'h0);
        chk("ar_wdata", 32'(rf_wdata), 32'h0);
        chk("ar_addr", 32'(rf_addr), 32'h0);
        chk("ar_pc", 32'(wb_pc), 32'h0);
        #1 rst = 1'b0;
        stall = 1'b0; flush = 1'b0; mem_valid = 1'b0;
        step();
        chk("ar_post_we", 32'(rf_we), 32'h0);
        // pending flush cleared by reset: next instruction commits
        drive(2'b01, 1'b1, 3'd6, 16'h0066, 16'h0400);
        step();
        chk("ar_post_commit", 32'(rf_we), 32'h1);
        chk("ar_post_cnt", 32'(retire_cnt), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
